// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude result decoder.
package sm_pkg;

    localparam int unsigned MAG_W = 3;
    localparam int unsigned TC_W  = MAG_W + 1;

    typedef struct packed {
        logic [TC_W-1:0] tc;
        logic            neg;
        logic            zero;
        logic            err;
    } sm_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Negative zero maps to 0; the range never overflows TC_W bits.
    function automatic logic [TC_W-1:0] sm_to_tc(input logic sign, input logic [MAG_W-1:0] mag);
        logic [TC_W-1:0] ext;
        ext = {1'b0, mag};
        return sign ? (TC_W'(0) - ext) : ext;
    endfunction

    function automatic logic sm_check(input logic [TC_W-1:0] r, input logic sf, input logic zf);
        logic sign;
        logic zero;
        sign = r[MAG_W];
        zero = (r[MAG_W-1:0] == '0);
        return (sf != sign) | (zf != (r == '0)) | (sign & zero);
    endfunction

endpackage

// File: rtl/sm_result_decoder_if.sv
// Producer/consumer handshake bundle for the result decoder.
interface sm_result_decoder_if #(
    parameter int unsigned MAG_W     = sm_pkg::MAG_W,
    parameter int unsigned ERR_CNT_W = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [MAG_W:0]       in_r;
    logic                 in_sf;
    logic                 in_zf;
    logic                 out_valid;
    logic                 out_ready;
    logic [MAG_W:0]       out_tc;
    logic                 out_neg;
    logic                 out_zero;
    logic                 out_err;
    logic                 clr_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, in_r, in_sf, in_zf, out_ready, clr_err,
        output in_ready, out_valid, out_tc, out_neg, out_zero, out_err, err_count
    );

    modport master (
        output in_valid, in_r, in_sf, in_zf, out_ready, clr_err,
        input  in_ready, out_valid, out_tc, out_neg, out_zero, out_err, err_count
    );

endinterface

// File: rtl/sm_fifo.sv
// Small synchronous FIFO with explicit EMPTY/PARTIAL/FULL occupancy state.
module sm_fifo
    import sm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    occ_e             occ_q, occ_d;
    logic             push;
    logic             pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        occ_d    = occ_q;
        push     = wr_en & (occ_q != OCC_FULL);
        pop      = rd_en & (occ_q != OCC_EMPTY);

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        case (occ_q)
            OCC_EMPTY:   if (push) occ_d = OCC_PARTIAL;
            OCC_PARTIAL: begin
                if (push && !pop && cnt_q == CNT_W'(DEPTH - 1)) occ_d = OCC_FULL;
                if (pop && !push && cnt_q == CNT_W'(1))         occ_d = OCC_EMPTY;
            end
            OCC_FULL:    if (pop) occ_d = OCC_PARTIAL;
            default:     occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is deliberately left unreset; validity comes from the occupancy state.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (occ_q == OCC_FULL);
    assign empty   = (occ_q == OCC_EMPTY);

endmodule

// File: rtl/sm_result_decoder.sv
// Decodes sign-magnitude results to two's complement, flags protocol errors and buffers them.
module sm_result_decoder #(
    parameter int unsigned MAG_W     = sm_pkg::MAG_W,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    sm_result_decoder_if.slave  bus
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    sm_pkg::sm_entry_t    wr_entry;
    sm_pkg::sm_entry_t    rd_entry;
    logic [MAG_W-1:0]     mag;
    logic                 sign;
    logic                 push;
    logic                 full;
    logic                 empty;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign mag  = bus.in_r[MAG_W-1:0];
    assign sign = bus.in_r[MAG_W];
    assign push = bus.in_valid & ~full;

    always_comb begin
        wr_entry.tc   = sm_pkg::sm_to_tc(sign, mag);
        wr_entry.zero = (mag == '0);
        wr_entry.neg  = sign & ~wr_entry.zero;
        wr_entry.err  = sm_pkg::sm_check(bus.in_r, bus.in_sf, bus.in_zf);
    end

    sm_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(sm_pkg::sm_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (bus.out_ready),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    // Clear wins over a same-cycle erroneous push.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.clr_err)                                      err_cnt_d = '0;
        else if (push && wr_entry.err && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_tc    = empty ? '0 : rd_entry.tc;
    assign bus.out_neg   = ~empty & rd_entry.neg;
    assign bus.out_zero  = ~empty & rd_entry.zero;
    assign bus.out_err   = ~empty & rd_entry.err;
    assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_sm_result_decoder.sv
// Scoreboard bench for sm_result_decoder: directed scenarios plus randomized traffic.
module tb_sm_result_decoder;

    localparam int unsigned MAG_W     = 3;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned ERR_CNT_W = 2;
    localparam int          ERR_SAT   = (1 << ERR_CNT_W) - 1;

    typedef struct packed {
        logic [MAG_W:0] tc;
        logic           neg;
        logic           zero;
        logic           err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   oready_mode;
    exp_t sbq[$];

    sm_result_decoder_if #(.MAG_W(MAG_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    sm_result_decoder #(
        .MAG_W     (MAG_W),
        .DEPTH     (DEPTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endfunction

    // Reference: interpret the word as a signed integer and derive flags from the rules.
    function automatic exp_t model(input logic [3:0] r, input logic sf, input logic zf);
        exp_t e;
        int   mag;
        int   v;
        bit   sign;
        mag    = int'(r[2:0]);
        sign   = r[3];
        v      = sign ? -mag : mag;
        e.tc   = 4'(v);
        e.zero = (mag == 0);
        e.neg  = (v < 0);
        e.err  = (sf != sign) || (zf != (r == 4'd0)) || (sign && mag == 0);
        return e;
    endfunction

    // out_ready driver: 0 = hold low, 1 = high, 2 = random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (oready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: occupancy, error counter and popped words against the scoreboard.
    initial begin : monitor
        int   occ;
        int   errm;
        bit   push;
        bit   pop;
        exp_t e;
        occ  = 0;
        errm = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                sbq.delete();
                occ  = 0;
                errm = 0;
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
                continue;
            end
            chk("in_ready", 32'(bus.in_ready), 32'(occ < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(occ != 0));
            chk("err_count", 32'(bus.err_count), 32'(errm));
            push = bus.in_valid && bus.in_ready;
            pop  = bus.out_valid && bus.out_ready;
            if (!bus.out_valid)
                chk("gated_outputs", 32'({bus.out_tc, bus.out_neg, bus.out_zero, bus.out_err}), 32'd0);
            if (pop) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("pop_word", 32'({bus.out_tc, bus.out_neg, bus.out_zero, bus.out_err}), 32'(e));
                end
            end
            if (bus.clr_err) errm = 0;
            else if (push && model(bus.in_r, bus.in_sf, bus.in_zf).err && errm < ERR_SAT) errm++;
            occ = occ + int'(push) - int'(pop);
        end
    end

    task automatic send(input logic [3:0] r, input logic sf, input logic zf, input logic clr);
        int t;
        t = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_r     = r;
        bus.in_sf    = sf;
        bus.in_zf    = zf;
        bus.clr_err  = clr;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sbq.push_back(model(r, sf, zf));
                break;
            end
            t++;
            if (t > 200) begin
                chk("send_timeout", 32'(t), 32'd0);
                break;
            end
            @(posedge clk); #1;
            bus.clr_err = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.clr_err  = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        oready_mode = 1;
        idle(1);
        while (sbq.size() != 0 && t < 300) begin
            @(negedge clk); #2;
            t++;
        end
        chk("drain_done", 32'(sbq.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic       sf;
        logic       zf;
        n_checks     = 0;
        n_pass       = 0;
        oready_mode  = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_sf    = 1'b0;
        bus.in_zf    = 1'b0;
        bus.clr_err  = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_err_count", 32'(bus.err_count), 32'd0);
        chk("reset_out_tc", 32'(bus.out_tc), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Single negative result
        send(4'b1011, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_out_tc", 32'(bus.out_tc), 32'hD);
        chk("t2_out_neg", 32'(bus.out_neg), 32'd1);
        chk("t2_out_err", 32'(bus.out_err), 32'd0);

        // Zero and negative zero
        send(4'b0000, 1'b0, 1'b1, 1'b0);
        send(4'b1000, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("t3_err_count", 32'(bus.err_count), 32'd1);
        drain();

        // Fill to full, hold off a fifth word, then release
        oready_mode = 0;
        send(4'b0011, 1'b0, 1'b0, 1'b0);
        send(4'b1011, 1'b1, 1'b0, 1'b0);
        send(4'b0111, 1'b0, 1'b0, 1'b0);
        send(4'b1111, 1'b1, 1'b0, 1'b0);
        fork
            send(4'b0001, 1'b0, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
                chk("t4_full_sb", 32'(sbq.size()), 32'd4);
                oready_mode = 1;
            end
        join
        drain();

        // Saturating error counter and clear priority
        for (int i = 0; i < 5; i++) send(4'b0010, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("t5_saturated", 32'(bus.err_count), 32'(ERR_SAT));
        send(4'b0001, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("t5_clr_priority", 32'(bus.err_count), 32'd0);
        drain();

        // Asynchronous reset with entries queued
        oready_mode = 0;
        send(4'b0001, 1'b0, 1'b0, 1'b0);
        send(4'b0010, 1'b0, 1'b0, 1'b0);
        idle(2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_async_out_tc", 32'(bus.out_tc), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(4'b0101, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t6_fresh_tc", 32'(bus.out_tc), 32'h5);
        drain();

        // Randomized traffic
        oready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r  = 4'($urandom_range(0, 15));
            sf = ($urandom_range(0, 7) == 0) ? ~r[3] : r[3];
            zf = ($urandom_range(0, 7) == 0) ? (r != 4'd0) : (r == 4'd0);
            send(r, sf, zf, ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
